fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter sitting in front of the write side of the asynchronous FIFO, in the FIFO's write clock domain. It shares the single `wr_en`/`fifo_in` port between `Num_Req` requesters, granting each requester a burst of up to `Burst_Len` words. Bursts stall while `fifo_full` is high, so the FIFO is never overwritten.

## Interface

**Parameters**
- `Width`, 8: data word width; matches the FIFO `Width`.
- `Num_Req`, 4: number of requesters, 2..8.
- `Burst_Len`, 4: maximum accepted words per grant, 1..16.

**Ports**
- `Clk1`  in  1: write-domain clock; the only clock.
- `Rst`  in  1: asynchronous, active-high reset.
- `req`  in  `Num_Req`: per-requester "word available".
- `req_data`  in  `Num_Req*Width`: requester k's data in bits `[k*Width +: Width]`.
- `fifo_full`  in  1: FIFO write-side full flag, already in the `Clk1` domain.
- `grant`  out  `Num_Req`: one-hot registered grant; all zero when idle.
- `ack`  out  `Num_Req`: one-hot; bit k high means requester k's word is written this cycle.
- `wr_en`  out  1: FIFO write enable.
- `fifo_in`  out  `Width`: FIFO write data.
- `busy`  out  1: high while in BURST.

## Operation

**FSM states:** IDLE, BURST. Encoding: IDLE=0, BURST=1.

**IDLE**
- `grant`=0, `wr_en`=0.
- If any `req` bit is high, pick the first requesting index strictly after `last_id`, searching round-robin modulo `Num_Req`.
- Then register `grant`, set `last_id` to that index, clear `beat_cnt`, and go to BURST.

**BURST**, with granted index g:
- Accept condition: `wr_en` = `req[g] & ~fifo_full`. This is combinational from the inputs.
- Data: `fifo_in` = `req_data[g]`. Outside BURST, `fifo_in` = 0.
- `ack` = `wr_en` ? onehot(g) : 0.
- On each accepted word, `beat_cnt` increments.
- Burst ends, returning to IDLE next cycle, when either:
  - an accepted word makes `beat_cnt` reach `Burst_Len`; or
  - `req[g]`=0 in BURST. No write occurs that cycle.
- `fifo_full`=1 with `req[g]`=1 is a stall:
  - no write;
  - `beat_cnt` and `grant` are held;
  - there is no timeout.
- The `req` bits of non-granted requesters are ignored during BURST.

**Width rules**
- `beat_cnt` is `$clog2(Burst_Len+1)` bits.
- `last_id` is `$clog2(Num_Req)` bits and wraps from `Num_Req-1` to 0.

## Timing

**Reset values**
- State: IDLE.
- `grant`, `ack`, `wr_en`, `fifo_in`, `busy`: 0.
- `beat_cnt`: 0.
- `last_id`: `Num_Req-1`, so requester 0 has first priority.

**Reset behaviour**
- Reset takes effect immediately, mid-burst included.
- The word in flight is not written.
- After deassertion, arbitration restarts on the next rising edge of `Clk1`.

**Latency**
- `req` rising in IDLE → `grant` at edge +1 → first `wr_en` in that same cycle, if not full.
- Arbitration bubble: exactly one cycle of `wr_en`=0 (IDLE) between consecutive bursts.
- With all requesters saturated and never full, throughput is `Burst_Len` writes per `Burst_Len+1` cycles.

**Simultaneous events**
- Last beat accepted while another requester's `req` rises: that request is considered in the following IDLE cycle.
- `fifo_full` rising in the same cycle as the last beat: the beat is not accepted and the burst stalls.
- Requester handshake: the requester must hold `req_data` stable while `req`=1 and `ack`=0, and advance its data on `ack`.

## Structure

- Shared package `fifo_pkg`:
  - `Width` and `Depth_Size` defaults, shared with the FIFO;
  - FSM state typedef/localparams (IDLE, BURST).
- Sub-module `rr_pick`:
  - combinational; inputs `req` and `last_id`;
  - outputs `any` and `next_id`;
  - parameterised by `Num_Req`.
- Top module: FSM, `beat_cnt`, `grant`/`last_id` registers, data mux.

## Test plan

All scenarios use `Num_Req`=4, `Burst_Len`=4.

1. **Reset:** assert `Rst` with `req`=4'b1111 → all outputs 0 during reset; first grant after release is `grant`=4'b0001.
2. **Single requester:** `req[2]` held high, data 1..8 advanced on `ack` → writes 1,2,3,4, one idle cycle, then writes 5,6,7,8, all with `grant`=4'b0100.
3. **Saturation:** `req`=4'b1111 → grant order 0,1,2,3,0; each burst 4 writes; `wr_en` pattern 4 high, 1 low, repeating.
4. **Full stall:** `fifo_full` high for 3 cycles after the 2nd beat of requester 1 → `wr_en`=0 for 3 cycles, `grant` held, then the remaining 2 beats; total 4 writes, no word lost or duplicated.
5. **Early drop:** `req[1]` drops after 2 accepted beats while `req[2]`=1 → BURST exits; next grant is requester 2 after one IDLE cycle.
6. **Reset mid-burst:** `Rst` pulse during requester 3's 2nd beat → `wr_en`/`grant` fall immediately; after release with `req`=4'b1001, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: defaults shared between the async FIFO and its write-side arbiter,
// plus the arbiter FSM state type.
package fifo_pkg;

    localparam int Width      = 8;
    localparam int Depth_Size = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bundle plus FIFO write port seen by the arbiter.
//   master : the arbiter (drives grant/ack/wr_en/fifo_in/busy)
//   slave  : requesters + FIFO (drive req/req_data/fifo_full)
interface fifo_wr_arbiter_if #(
    parameter int Width   = 8,
    parameter int Num_Req = 4
);
    logic [Num_Req-1:0]       req;
    logic [Num_Req*Width-1:0] req_data;
    logic                     fifo_full;
    logic [Num_Req-1:0]       grant;
    logic [Num_Req-1:0]       ack;
    logic                     wr_en;
    logic [Width-1:0]         fifo_in;
    logic                     busy;

    modport master (
        input  req, req_data, fifo_full,
        output grant, ack, wr_en, fifo_in, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  grant, ack, wr_en, fifo_in, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req     : request vector
//   last_id : previously granted index
//   any     : at least one request is pending
//   next_id : first requesting index strictly after last_id (mod Num_Req);
//             equals last_id when nothing is requesting
module rr_pick #(
    parameter  int Num_Req = 4,
    localparam int IdW     = $clog2(Num_Req)
) (
    input  logic [Num_Req-1:0] req,
    input  logic [IdW-1:0]     last_id,
    output logic               any,
    output logic [IdW-1:0]     next_id
);

    logic [IdW-1:0] idx;

    assign any = |req;

    // Scan from the farthest offset down to +1 so the nearest candidate after
    // last_id is the one left standing.
    always_comb begin
        next_id = last_id;
        idx     = '0;
        for (int i = Num_Req; i >= 1; i--) begin
            idx = IdW'((int'(last_id) + i) % Num_Req);
            if (req[idx]) next_id = idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// Num_Req requesters, up to Burst_Len words per grant, stalling on fifo_full.
//   Clk1 : write-domain clock
//   Rst  : asynchronous active-high reset
//   bus  : req/req_data/fifo_full in; grant/ack/wr_en/fifo_in/busy out
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter  int Width     = fifo_pkg::Width,
    parameter  int Num_Req   = 4,
    parameter  int Burst_Len = 4,
    localparam int IdW       = $clog2(Num_Req),
    localparam int BcW       = $clog2(Burst_Len + 1)
) (
    input  logic               Clk1,
    input  logic               Rst,
    fifo_wr_arbiter_if.master  bus
);

    arb_state_t         state, state_nxt;
    logic [Num_Req-1:0] grant, grant_nxt;
    logic [IdW-1:0]     last_id, last_nxt;
    logic [BcW-1:0]     beat_cnt, beat_nxt;

    logic               any;
    logic [IdW-1:0]     pick_id;
    logic               in_burst;
    logic               req_g;
    logic               accept;
    logic [Width-1:0]   words [Num_Req];

    rr_pick #(.Num_Req(Num_Req)) u_pick (
        .req     (bus.req),
        .last_id (last_id),
        .any     (any),
        .next_id (pick_id)
    );

    for (genvar k = 0; k < Num_Req; k++) begin : g_word
        assign words[k] = bus.req_data[k*Width +: Width];
    end

    // last_id is loaded with the granted index, so it doubles as g in BURST.
    assign in_burst = (state == BURST);
    assign req_g    = bus.req[last_id];
    assign accept   = in_burst & req_g & ~bus.fifo_full;

    assign bus.grant   = grant;
    assign bus.busy    = in_burst;
    assign bus.wr_en   = accept;
    assign bus.ack     = accept ? grant : '0;
    assign bus.fifo_in = in_burst ? words[last_id] : '0;

    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            state    <= IDLE;
            grant    <= '0;
            last_id  <= IdW'(Num_Req - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            last_id  <= last_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last_id;
        beat_nxt  = beat_cnt;
        case (state)
            IDLE: begin
                if (any) begin
                    state_nxt = BURST;
                    grant_nxt = Num_Req'(1) << pick_id;
                    last_nxt  = pick_id;
                    beat_nxt  = '0;
                end
            end
            BURST: begin
                if (!req_g) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end else if (accept) begin
                    beat_nxt = beat_cnt + 1'b1;
                    if (beat_cnt == BcW'(Burst_Len - 1)) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
                // full with req held: stall, everything holds
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter: requesters push each word they offer
// into a per-requester scoreboard queue; a negedge monitor checks outputs
// against a behavioural model of the arbitration rules and pops on writes.
module tb_fifo_wr_arbiter;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int BL = 4;

    logic Clk1;
    logic Rst;

    fifo_wr_arbiter_if #(.Width(W), .Num_Req(NR)) bus ();

    fifo_wr_arbiter #(.Width(W), .Num_Req(NR), .Burst_Len(BL)) dut (
        .Clk1 (Clk1),
        .Rst  (Rst),
        .bus  (bus)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [W-1:0]  exp_q [NR][$];
    logic [NR-1:0] ack_s = '0;

    // model state
    bit           m_busy = 1'b0;
    int           m_g    = 0;
    int           m_last = NR - 1;
    int           m_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / model ----------------
    initial begin : monitor
        logic          e_wr;
        logic [NR-1:0] e_grant;
        logic [W-1:0]  e_data;
        int            pick;
        forever begin
            @(negedge Clk1);
            ack_s = bus.ack;
            if (Rst) begin
                chk("rst_grant", 32'(bus.grant), 0);
                chk("rst_ack", 32'(bus.ack), 0);
                chk("rst_wr_en", 32'(bus.wr_en), 0);
                chk("rst_fifo_in", 32'(bus.fifo_in), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                m_busy  = 1'b0;
                m_last  = NR - 1;
                m_beats = 0;
            end else begin
                e_wr    = m_busy && bus.req[m_g] && !bus.fifo_full;
                e_grant = m_busy ? NR'(1 << m_g) : '0;
                if (!m_busy)   e_data = '0;
                else if (e_wr) e_data = (exp_q[m_g].size() > 0) ? exp_q[m_g][0] : 'x;
                else           e_data = bus.req_data[m_g*W +: W];
                chk("grant", 32'(bus.grant), 32'(e_grant));
                chk("busy", 32'(bus.busy), 32'(m_busy));
                chk("wr_en", 32'(bus.wr_en), 32'(e_wr));
                chk("ack", 32'(bus.ack), e_wr ? 32'(e_grant) : 0);
                chk("fifo_in", 32'(bus.fifo_in), 32'(e_data));
                if (e_wr && exp_q[m_g].size() > 0) void'(exp_q[m_g].pop_front());

                // advance model by one clock
                if (!m_busy) begin
                    pick = -1;
                    for (int i = 1; i <= NR; i++)
                        if (pick < 0 && bus.req[(m_last + i) % NR]) pick = (m_last + i) % NR;
                    if (pick >= 0) begin
                        m_busy  = 1'b1;
                        m_g     = pick;
                        m_last  = pick;
                        m_beats = 0;
                    end
                end else if (!bus.req[m_g]) begin
                    m_busy = 1'b0;
                end else if (!bus.fifo_full) begin
                    m_beats++;
                    if (m_beats == BL) m_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- requesters / stimulus ----------------
    task automatic run(input logic [NR-1:0] mask, input int p_up, input int p_dn,
                       input int p_full, input int p_rst, input int n);
        logic [W-1:0] w;
        for (int c = 0; c < n; c++) begin
            @(posedge Clk1);
            #1;
            Rst = ($urandom_range(99) < p_rst);
            for (int k = 0; k < NR; k++) begin
                if (ack_s[k]) begin
                    w = W'($urandom);
                    bus.req_data[k*W +: W] = w;
                    exp_q[k].push_back(w);
                end
                if (!mask[k])                                    bus.req[k] = 1'b0;
                else if (bus.req[k] && $urandom_range(99) < p_dn) bus.req[k] = 1'b0;
                else if (!bus.req[k] && $urandom_range(99) < p_up) bus.req[k] = 1'b1;
            end
            bus.fifo_full = ($urandom_range(99) < p_full);
        end
    endtask

    initial begin : driver
        logic [W-1:0] w;
        Rst           = 1'b1;
        bus.req       = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = '0;
        for (int k = 0; k < NR; k++) begin
            w = W'(k + 1);
            bus.req_data[k*W +: W] = w;
            exp_q[k].push_back(w);
        end
        run(4'b1111, 100, 0, 0, 100, 3);   // reset held with all requesting
        run(4'b1111, 100, 0, 0, 0, 25);    // saturation
        run(4'b0100, 100, 0, 0, 0, 20);    // single requester
        run(4'b0010, 100, 0, 40, 0, 40);   // stalls on one requester
        run(4'b0110, 60, 30, 0, 0, 60);    // early drops handing over to req 2
        run(4'b1111, 100, 0, 30, 0, 200);  // saturated with full
        run(4'b1111, 50, 20, 25, 2, 2000); // everything random, incl. resets
        run(4'b1001, 100, 0, 0, 0, 20);
        run(4'b0000, 0, 0, 0, 0, 4);
        @(posedge Clk1);
        @(negedge Clk1);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
